// File: rtl/ppu_pkg.sv
// Shared pattern-fetch definitions: ROM geometry, arbiter states, requester ids.
package ppu_pkg;

    localparam int PATTERN_ADDR_W = 14;
    localparam int PATTERN_DATA_W = 8;
    localparam int PLANE_OFFSET   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_BG  = 1'b0,
        REQ_SPR = 1'b1
    } req_id_e;

endpackage

// File: rtl/pattern_rom_arbiter_if.sv
// Pattern ROM bus: two fetcher request/response channels plus the ROM port.
interface pattern_rom_arbiter_if
    import ppu_pkg::*;
#(
    parameter int ADDR_W = ppu_pkg::PATTERN_ADDR_W,
    parameter int DATA_W = ppu_pkg::PATTERN_DATA_W
);
    logic              bg_req;
    logic [ADDR_W-1:0] bg_addr;
    logic              bg_pair;
    logic              bg_gnt;
    logic              bg_rsp_valid;

    logic              spr_req;
    logic [ADDR_W-1:0] spr_addr;
    logic              spr_pair;
    logic              spr_gnt;
    logic              spr_rsp_valid;

    logic              rsp_plane;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    // Arbiter side
    modport slave (
        input  bg_req, bg_addr, bg_pair,
        output bg_gnt, bg_rsp_valid,
        input  spr_req, spr_addr, spr_pair,
        output spr_gnt, spr_rsp_valid,
        output rsp_plane, rsp_data,
        output rom_addr,
        input  rom_q
    );

    // Fetcher / ROM side
    modport master (
        output bg_req, bg_addr, bg_pair,
        input  bg_gnt, bg_rsp_valid,
        output spr_req, spr_addr, spr_pair,
        input  spr_gnt, spr_rsp_valid,
        input  rsp_plane, rsp_data,
        input  rom_addr,
        output rom_q
    );

endinterface

// File: rtl/pattern_rom_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, ties go to ptr.
module rr_arb2
    import ppu_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    ptr,
    output logic [1:0] gnt
);

    // One-hot grant; bit 0 = bg, bit 1 = spr
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (ptr == REQ_SPR) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/pattern_rom_arbiter.sv
// Shares one synchronous pattern ROM between the background and sprite
// fetchers. Single reads take one cycle; paired reads issue addr then
// addr+PLANE_OFFSET on consecutive cycles. Data returns one cycle later.
module pattern_rom_arbiter #(
    parameter int ADDR_W       = ppu_pkg::PATTERN_ADDR_W,
    parameter int DATA_W       = ppu_pkg::PATTERN_DATA_W,
    parameter int PLANE_OFFSET = ppu_pkg::PLANE_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_rom_arbiter_if.slave  bus
);
    import ppu_pkg::*;

    arb_state_e        st;
    req_id_e           ptr;        // preferred requester on a tie
    req_id_e           lat_id;     // owner of the grant in flight
    logic [ADDR_W-1:0] lat_addr;   // low-plane address of a paired grant
    logic [ADDR_W-1:0] last_addr;  // held on rom_addr while idle
    logic              rsp_vld;
    req_id_e           rsp_id;
    logic              rsp_pl;

    logic [1:0]        req;
    logic [1:0]        gnt;
    req_id_e           gnt_id;
    logic              gnt_pair;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] rom_q_w;

    // Only arbitrate in IDLE and never while reset is asserted
    assign req = (st == IDLE && !rst) ? {bus.spr_req, bus.bg_req} : 2'b00;

    rr_arb2 u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign gnt_id   = gnt[1] ? REQ_SPR : REQ_BG;
    assign gnt_pair = gnt[1] ? bus.spr_pair : bus.bg_pair;

    // ROM address: high plane in SECOND, granted address in IDLE, else hold
    always_comb begin
        addr_c = last_addr;
        if (rst)
            addr_c = '0;
        else if (st == SECOND)
            addr_c = lat_addr + ADDR_W'(PLANE_OFFSET);
        else if (gnt[0])
            addr_c = bus.bg_addr;
        else if (gnt[1])
            addr_c = bus.spr_addr;
    end

    // Arbiter FSM; the pair bit is captured by the transition into SECOND
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            ptr       <= REQ_BG;
            lat_id    <= REQ_BG;
            lat_addr  <= '0;
            last_addr <= '0;
            rsp_vld   <= 1'b0;
            rsp_id    <= REQ_BG;
            rsp_pl    <= 1'b0;
        end else begin
            last_addr <= addr_c;
            case (st)
                IDLE: begin
                    if (|gnt) begin
                        lat_id   <= gnt_id;
                        lat_addr <= addr_c;
                        ptr      <= (gnt_id == REQ_BG) ? REQ_SPR : REQ_BG;
                        rsp_vld  <= 1'b1;
                        rsp_id   <= gnt_id;
                        rsp_pl   <= 1'b0;
                        st       <= gnt_pair ? SECOND : IDLE;
                    end else begin
                        rsp_vld  <= 1'b0;
                    end
                end
                SECOND: begin
                    rsp_vld <= 1'b1;
                    rsp_id  <= lat_id;
                    rsp_pl  <= 1'b1;
                    st      <= IDLE;
                end
                default: begin
                    rsp_vld <= 1'b0;
                    st      <= IDLE;
                end
            endcase
        end
    end

    assign rom_q_w           = bus.rom_q;
    assign bus.rom_addr      = addr_c;
    assign bus.bg_gnt        = gnt[0];
    assign bus.spr_gnt       = gnt[1];
    // Reset masks a response already in the pipe
    assign bus.bg_rsp_valid  = !rst && rsp_vld && (rsp_id == REQ_BG);
    assign bus.spr_rsp_valid = !rst && rsp_vld && (rsp_id == REQ_SPR);
    assign bus.rsp_plane     = !rst && rsp_pl;
    assign bus.rsp_data      = rom_q_w;

endmodule

// File: tb/tb_pattern_rom_arbiter.sv
// Bench for pattern_rom_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_pattern_rom_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_rom_arbiter_if bus ();

    pattern_rom_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM model: contents known to the bench, read latency one cycle
    logic [7:0] bg_test_rom [0:16383];
    always @(posedge clk) bus.rom_q <= bg_test_rom[bus.rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level)
    logic        m_second;     // high-plane read owed next cycle
    logic        m_so;         // its owner (1 = spr)
    logic [13:0] m_sa;         // its low-plane address
    logic        m_last_spr;   // most recent grant went to spr
    logic [13:0] m_last_addr;
    logic        m_pv, m_po, m_pp;
    logic [13:0] m_pa;         // address whose data is due next cycle

    logic        e_bg_gnt, e_spr_gnt, e_bgv, e_sprv, e_plane;
    logic [13:0] e_addr;
    logic [7:0]  e_data;

    // Expected outputs for this cycle from current inputs, then advance model
    task automatic model_cycle();
        logic        win_spr;
        logic [13:0] a;
        e_bg_gnt = 0; e_spr_gnt = 0; e_bgv = 0; e_sprv = 0; e_plane = 0; e_data = '0;
        if (rst) begin
            e_addr = '0; m_second = 0; m_last_spr = 1; m_last_addr = '0; m_pv = 0;
        end else begin
            if (m_pv) begin
                e_bgv = !m_po; e_sprv = m_po; e_plane = m_pp; e_data = bg_test_rom[m_pa];
            end
            m_pv = 0;
            if (m_second) begin
                a = m_sa + 14'd8;
                e_addr = a; m_pv = 1; m_po = m_so; m_pp = 1; m_pa = a; m_second = 0;
            end else if (bus.bg_req || bus.spr_req) begin
                win_spr = (bus.bg_req && bus.spr_req) ? !m_last_spr : bus.spr_req;
                a = win_spr ? bus.spr_addr : bus.bg_addr;
                e_bg_gnt = !win_spr; e_spr_gnt = win_spr; e_addr = a;
                m_pv = 1; m_po = win_spr; m_pp = 0; m_pa = a; m_last_spr = win_spr;
                if (win_spr ? bus.spr_pair : bus.bg_pair) begin
                    m_second = 1; m_sa = a; m_so = win_spr;
                end
            end else begin
                e_addr = m_last_addr;
            end
            m_last_addr = e_addr;
        end
    endtask

    task automatic eval_cycle();
        model_cycle();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.bg_req = 0; bus.bg_addr = '0; bus.bg_pair = 0;
        bus.spr_req = 0; bus.spr_addr = '0; bus.spr_pair = 0;
    endtask

    task automatic test_reset();
        rst = 1; quiet_inputs();
        bus.bg_req = 1; bus.bg_addr = 14'h0123;
        for (int i = 0; i < 2; i++) begin
            eval_cycle();
            n_checks++; if (bus.rom_addr !== 14'h0) begin n_fail++; $display("FAIL reset rom_addr got %h exp 0000", bus.rom_addr); end
            n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset gnt got %b exp 00", {bus.bg_gnt, bus.spr_gnt}); end
            n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane} !== 3'b000) begin n_fail++; $display("FAIL reset rsp got %b exp 000", {bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane}); end
            next_cycle();
        end
        rst = 0; quiet_inputs();
    endtask

    task automatic test_single();
        bus.bg_req = 1; bus.bg_addr = 14'h0010; bus.bg_pair = 0;
        eval_cycle();
        n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== 2'b10) begin n_fail++; $display("FAIL single gnt got %b exp 10", {bus.bg_gnt, bus.spr_gnt}); end
        n_checks++; if (bus.rom_addr !== 14'h0010) begin n_fail++; $display("FAIL single rom_addr got %h exp 0010", bus.rom_addr); end
        next_cycle();
        bus.bg_req = 0; bus.bg_addr = 14'h2AAA;
        eval_cycle();
        n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane} !== 3'b100) begin n_fail++; $display("FAIL single rsp got %b exp 100", {bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane}); end
        n_checks++; if (bus.rsp_data !== bg_test_rom[14'h0010]) begin n_fail++; $display("FAIL single data got %h exp %h", bus.rsp_data, bg_test_rom[14'h0010]); end
        n_checks++; if (bus.bg_gnt !== 1'b0) begin n_fail++; $display("FAIL single regrant got %b exp 0", bus.bg_gnt); end
        next_cycle();
    endtask

    // Paired read; the requester scrambles its address after the grant
    task automatic test_pair(input logic spr, input logic [13:0] a, input logic [13:0] a2);
        if (spr) begin bus.spr_req = 1; bus.spr_addr = a; bus.spr_pair = 1; end
        else     begin bus.bg_req = 1;  bus.bg_addr = a;  bus.bg_pair = 1;  end
        eval_cycle();
        n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== (spr ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL pair gnt got %b", {bus.bg_gnt, bus.spr_gnt}); end
        n_checks++; if (bus.rom_addr !== a) begin n_fail++; $display("FAIL pair addr0 got %h exp %h", bus.rom_addr, a); end
        next_cycle();
        quiet_inputs(); bus.bg_addr = 14'h1555; bus.spr_addr = 14'h0AAA;
        eval_cycle();
        n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== 2'b00) begin n_fail++; $display("FAIL pair gnt in second got %b exp 00", {bus.bg_gnt, bus.spr_gnt}); end
        n_checks++; if (bus.rom_addr !== a2) begin n_fail++; $display("FAIL pair addr1 got %h exp %h", bus.rom_addr, a2); end
        n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane} !== {!spr, spr, 1'b0}) begin n_fail++; $display("FAIL pair rsp0 got %b", {bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane}); end
        n_checks++; if (bus.rsp_data !== bg_test_rom[a]) begin n_fail++; $display("FAIL pair data0 got %h exp %h", bus.rsp_data, bg_test_rom[a]); end
        next_cycle();
        eval_cycle();
        n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane} !== {!spr, spr, 1'b1}) begin n_fail++; $display("FAIL pair rsp1 got %b", {bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane}); end
        n_checks++; if (bus.rsp_data !== bg_test_rom[a2]) begin n_fail++; $display("FAIL pair data1 got %h exp %h", bus.rsp_data, bg_test_rom[a2]); end
        next_cycle();
    endtask

    task automatic test_idle_hold(input logic [13:0] held);
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            eval_cycle();
            n_checks++; if (bus.rom_addr !== held) begin n_fail++; $display("FAIL idle addr got %h exp %h", bus.rom_addr, held); end
            n_checks++; if ({bus.bg_gnt, bus.spr_gnt, bus.bg_rsp_valid, bus.spr_rsp_valid} !== 4'b0) begin n_fail++; $display("FAIL idle activity got %b exp 0000", {bus.bg_gnt, bus.spr_gnt, bus.bg_rsp_valid, bus.spr_rsp_valid}); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        rst = 1; quiet_inputs();
        eval_cycle(); next_cycle();
        rst = 0;
        bus.bg_req = 1; bus.bg_addr = 14'h0100; bus.spr_req = 1; bus.spr_addr = 14'h0200;
        for (int i = 0; i < 8; i++) begin
            eval_cycle();
            n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b gnt cyc %0d got %b", i, {bus.bg_gnt, bus.spr_gnt}); end
            n_checks++; if (bus.rom_addr !== ((i % 2 == 0) ? 14'h0100 : 14'h0200)) begin n_fail++; $display("FAIL b2b addr cyc %0d got %h", i, bus.rom_addr); end
            if (i > 0) begin
                n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b rsp cyc %0d got %b", i, {bus.bg_rsp_valid, bus.spr_rsp_valid}); end
            end
            next_cycle();
        end
        quiet_inputs();
        eval_cycle(); next_cycle();
    endtask

    task automatic test_reset_abort();
        quiet_inputs();
        bus.bg_req = 1; bus.bg_addr = 14'h0200; bus.bg_pair = 1;
        eval_cycle();
        n_checks++; if (bus.bg_gnt !== 1'b1) begin n_fail++; $display("FAIL abort gnt got %b exp 1", bus.bg_gnt); end
        next_cycle();
        rst = 1; quiet_inputs();
        eval_cycle();
        n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane, bus.bg_gnt, bus.spr_gnt} !== 5'b0) begin n_fail++; $display("FAIL abort outputs in reset got %b exp 00000", {bus.bg_rsp_valid, bus.spr_rsp_valid, bus.rsp_plane, bus.bg_gnt, bus.spr_gnt}); end
        n_checks++; if (bus.rom_addr !== 14'h0) begin n_fail++; $display("FAIL abort rom_addr got %h exp 0000", bus.rom_addr); end
        next_cycle();
        rst = 0; bus.bg_req = 1; bus.bg_addr = 14'h0300; bus.bg_pair = 0;
        eval_cycle();
        n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL abort late rsp got %b exp 00", {bus.bg_rsp_valid, bus.spr_rsp_valid}); end
        n_checks++; if (bus.bg_gnt !== 1'b1 || bus.rom_addr !== 14'h0300) begin n_fail++; $display("FAIL abort regrant got gnt %b addr %h exp 1 0300", bus.bg_gnt, bus.rom_addr); end
        next_cycle();
        quiet_inputs();
        eval_cycle();
        n_checks++; if (bus.bg_rsp_valid !== 1'b1 || bus.rsp_data !== bg_test_rom[14'h0300]) begin n_fail++; $display("FAIL abort new rsp got v %b d %h exp 1 %h", bus.bg_rsp_valid, bus.rsp_data, bg_test_rom[14'h0300]); end
        next_cycle();
    endtask

    // Fetchers hold requests until granted, occasionally abandon them,
    // and reset is pulsed now and then
    task automatic test_random();
        quiet_inputs();
        for (int c = 0; c < 3000; c++) begin
            eval_cycle();
            n_checks++; if ({bus.bg_gnt, bus.spr_gnt} !== {e_bg_gnt, e_spr_gnt}) begin n_fail++; $display("FAIL rnd gnt cyc %0d got %b exp %b", c, {bus.bg_gnt, bus.spr_gnt}, {e_bg_gnt, e_spr_gnt}); end
            n_checks++; if (bus.rom_addr !== e_addr) begin n_fail++; $display("FAIL rnd rom_addr cyc %0d got %h exp %h", c, bus.rom_addr, e_addr); end
            n_checks++; if ({bus.bg_rsp_valid, bus.spr_rsp_valid} !== {e_bgv, e_sprv}) begin n_fail++; $display("FAIL rnd rsp_valid cyc %0d got %b exp %b", c, {bus.bg_rsp_valid, bus.spr_rsp_valid}, {e_bgv, e_sprv}); end
            if (e_bgv || e_sprv || rst) begin
                n_checks++; if (bus.rsp_plane !== e_plane) begin n_fail++; $display("FAIL rnd plane cyc %0d got %b exp %b", c, bus.rsp_plane, e_plane); end
            end
            if (e_bgv || e_sprv) begin
                n_checks++; if (bus.rsp_data !== e_data) begin n_fail++; $display("FAIL rnd data cyc %0d got %h exp %h", c, bus.rsp_data, e_data); end
            end
            next_cycle();
            rst = ($urandom_range(0, 63) == 0);
            if (e_bg_gnt || !bus.bg_req) begin
                bus.bg_req = ($urandom_range(0, 2) != 0); bus.bg_addr = 14'($urandom); bus.bg_pair = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.bg_req = 0;
            end
            if (e_spr_gnt || !bus.spr_req) begin
                bus.spr_req = ($urandom_range(0, 2) != 0); bus.spr_addr = 14'($urandom); bus.spr_pair = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.spr_req = 0;
            end
        end
        rst = 0; quiet_inputs();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) bg_test_rom[i] = 8'((i * 7) ^ (i >> 6) ^ 8'h5A);
        m_second = 0; m_so = 0; m_sa = '0; m_last_spr = 1; m_last_addr = '0;
        m_pv = 0; m_po = 0; m_pp = 0; m_pa = '0;
        rst = 1; quiet_inputs();
        #1;
        test_reset();
        test_single();
        test_pair(1'b1, 14'h1230, 14'h1238);
        test_pair(1'b0, 14'h3FFC, 14'h0004);
        test_idle_hold(14'h0004);
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
